// File: rtl/id_stage.sv
// Decode stage: IF/ID register, field split, double-word increments, PC-relative targets.
// Define ID_HAZARD_DETECT_EN to build the EX load tracker and load-use stall.
module id_stage (
  input  logic        clk,
  input  logic        clear,
  input  logic [31:0] inst_in,
  input  logic [31:0] pc_next_in,
  input  logic        add_rd_in,
  input  logic        add_imm_in,
  input  logic        stall_in,
  input  logic        flush_in,
  output logic        hazard_stall,
  output logic        valid_out,
  output logic        issue_out,
  output logic [5:0]  opcode_out,
  output logic [3:0]  rd_out,
  output logic [3:0]  rs_out,
  output logic [3:0]  rt_out,
  output logic [31:0] imm_out,
  output logic [31:0] pc_next_out,
  output logic [31:0] branch_target,
  output logic [31:0] jump_target
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        add_rd;
    logic        add_imm;
    logic        valid;
  } if_id_t;

  if_id_t q;

  logic [31:0] imm_sx;
  logic [31:0] jmp_sx;
  logic [31:0] pc_cur;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      q <= '0;
    end else if (flush_in) begin
      q.valid <= 1'b0;
      q.inst  <= '0;
    end else if (!(stall_in || hazard_stall)) begin
      q.inst    <= inst_in;
      q.pc      <= pc_next_in;
      q.add_rd  <= add_rd_in;
      q.add_imm <= add_imm_in;
      q.valid   <= 1'b1;
    end
  end

  assign imm_sx = {{18{q.inst[13]}}, q.inst[13:0]};
  assign jmp_sx = {{6{q.inst[25]}}, q.inst[25:0]};
  assign pc_cur = q.pc - 32'd1;

  assign valid_out   = q.valid;
  assign opcode_out  = q.inst[31:26];
  assign rd_out      = q.inst[25:22] + {3'b000, q.add_rd};
  assign rs_out      = q.inst[21:18];
  assign rt_out      = q.inst[17:14];
  assign imm_out     = imm_sx + {31'd0, q.add_imm};
  assign pc_next_out = q.pc;

  // Targets read as 0 with no instruction held, so reset leaves every output at 0.
  assign branch_target = q.valid ? pc_cur + imm_sx : '0;
  assign jump_target   = q.valid ? pc_cur + jmp_sx : '0;

  assign issue_out = q.valid && !hazard_stall;

`ifdef ID_HAZARD_DETECT_EN
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd6;
  localparam logic [5:0] OP_SW    = 6'd7;
  localparam logic [5:0] OP_LWD   = 6'd8;
  localparam logic [5:0] OP_SWD   = 6'd9;

  logic       ex_load_valid;
  logic [3:0] ex_rd;
  logic       is_load;
  logic       is_store;
  logic       src_hit;

  assign is_load  = (opcode_out == OP_LW) || (opcode_out == OP_LWD);
  assign is_store = (opcode_out == OP_SW) || (opcode_out == OP_SWD);

  assign src_hit = (rs_out == ex_rd)
                || ((opcode_out == OP_RTYPE) && (rt_out == ex_rd))
                || (is_store && (rd_out == ex_rd));

  assign hazard_stall = ex_load_valid && q.valid && src_hit;

  // A stall cycle sends a bubble to EX, so the tracker drops the load.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      ex_load_valid <= 1'b0;
      ex_rd         <= '0;
    end else if (flush_in) begin
      ex_load_valid <= 1'b0;
    end else if (stall_in) begin
      ex_load_valid <= ex_load_valid;
    end else if (hazard_stall) begin
      ex_load_valid <= 1'b0;
    end else begin
      ex_load_valid <= q.valid && is_load;
      ex_rd         <= rd_out;
    end
  end
`else
  assign hazard_stall = 1'b0;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Randomized + directed bench for id_stage against a field-level reference model.
// Works with or without ID_HAZARD_DETECT_EN defined.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        clear;
  logic [31:0] inst_in, pc_next_in;
  logic        add_rd_in, add_imm_in, stall_in, flush_in;
  logic        hazard_stall, valid_out, issue_out;
  logic [5:0]  opcode_out;
  logic [3:0]  rd_out, rs_out, rt_out;
  logic [31:0] imm_out, pc_next_out, branch_target, jump_target;

  int tests = 0;
  int fails = 0;

  id_stage dut (
    .clk(clk), .clear(clear), .inst_in(inst_in), .pc_next_in(pc_next_in),
    .add_rd_in(add_rd_in), .add_imm_in(add_imm_in), .stall_in(stall_in),
    .flush_in(flush_in), .hazard_stall(hazard_stall), .valid_out(valid_out),
    .issue_out(issue_out), .opcode_out(opcode_out), .rd_out(rd_out),
    .rs_out(rs_out), .rt_out(rt_out), .imm_out(imm_out),
    .pc_next_out(pc_next_out), .branch_target(branch_target),
    .jump_target(jump_target)
  );

  always #5 clk = ~clk;

  logic [31:0] m_inst, m_pc;
  bit          m_ard, m_aimm, m_v, m_elv;
  int          m_erd;

  function automatic int f_op();  return int'(m_inst[31:26]); endfunction
  function automatic int f_rs();  return int'(m_inst[21:18]); endfunction
  function automatic int f_rt();  return int'(m_inst[17:14]); endfunction
  function automatic int f_rd();
    return (int'(m_inst[25:22]) + int'(m_ard)) % 16;
  endfunction
  function automatic int s_imm();
    return int'(m_inst[13:0]) - (m_inst[13] ? 16384 : 0);
  endfunction
  function automatic int s_jmp();
    return int'(m_inst[25:0]) - (m_inst[25] ? 67108864 : 0);
  endfunction
  function automatic bit f_haz();
`ifdef ID_HAZARD_DETECT_EN
    bit hit;
    hit = (f_rs() == m_erd)
       || (f_op() == 0 && f_rt() == m_erd)
       || ((f_op() == 7 || f_op() == 9) && f_rd() == m_erd);
    return m_v && m_elv && hit;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_inst = 0; m_pc = 0; m_ard = 0; m_aimm = 0;
    m_v = 0; m_elv = 0; m_erd = 0;
  endtask

  task automatic model_edge();
    bit h, v0;
    int op, rd;
    h = f_haz(); v0 = m_v; op = f_op(); rd = f_rd();
    if (flush_in) begin
      m_v = 0; m_inst = 0;
    end else if (!(stall_in || h)) begin
      m_inst = inst_in; m_pc = pc_next_in;
      m_ard = add_rd_in; m_aimm = add_imm_in; m_v = 1;
    end
`ifdef ID_HAZARD_DETECT_EN
    if (flush_in) m_elv = 0;
    else if (stall_in) m_elv = m_elv;
    else if (h) m_elv = 0;
    else begin
      m_elv = v0 && (op == 6 || op == 8);
      m_erd = rd;
    end
`endif
  endtask

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", n, a, e, $time);
    end
  endtask

  task automatic check_all();
    logic [31:0] bt, jt;
    bit h;
    h  = f_haz();
    bt = m_v ? m_pc - 32'd1 + 32'(s_imm()) : 32'd0;
    jt = m_v ? m_pc - 32'd1 + 32'(s_jmp()) : 32'd0;
    chk("valid", 32'(valid_out), 32'(m_v));
    chk("hazard", 32'(hazard_stall), 32'(h));
    chk("issue", 32'(issue_out), 32'(m_v && !h));
    chk("opcode", 32'(opcode_out), 32'(f_op()));
    chk("rd", 32'(rd_out), 32'(f_rd()));
    chk("rs", 32'(rs_out), 32'(f_rs()));
    chk("rt", 32'(rt_out), 32'(f_rt()));
    chk("imm", imm_out, 32'(s_imm() + int'(m_aimm)));
    chk("pc_next", pc_next_out, m_pc);
    chk("branch", branch_target, bt);
    chk("jump", jump_target, jt);
  endtask

  task automatic step(logic [31:0] i, logic [31:0] p, bit ar, bit ai,
                      bit st, bit fl);
    inst_in = i; pc_next_in = p; add_rd_in = ar; add_imm_in = ai;
    stall_in = st; flush_in = fl;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    clear = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_branch", branch_target, 32'd0);
    chk("rst_pc", pc_next_out, 32'd0);
    @(negedge clk);
    clear = 1'b1;
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [5:0] ops [8];
    logic [5:0] op;
    ops = '{6'd0, 6'd6, 6'd7, 6'd8, 6'd9, 6'd2, 6'd11, 6'd6};
    if ($urandom_range(0, 15) == 0) return $urandom();
    op = ops[$urandom_range(0, 7)];
    return {op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            4'($urandom_range(0, 3)), 14'($urandom())};
  endfunction

  localparam logic [31:0] LW   = 32'h18C00000;
  localparam logic [31:0] ADDI = 32'h080C0000;
  localparam logic [31:0] ND   = 32'h04400000;

  initial begin
    clear = 1'b0;
    inst_in = 0; pc_next_in = 0; add_rd_in = 0; add_imm_in = 0;
    stall_in = 0; flush_in = 0;
    model_reset();
    #1;
    check_all();
    chk("init_valid", 32'(valid_out), 32'd0);
    @(negedge clk);
    clear = 1'b1;

    step(32'h2C143FFD, 32'd8, 0, 0, 0, 0);
    chk("dec_opcode", 32'(opcode_out), 32'd11);
    chk("dec_rs", 32'(rs_out), 32'd5);
    chk("dec_rd", 32'(rd_out), 32'd0);
    chk("dec_imm", imm_out, 32'hFFFFFFFD);
    chk("dec_branch", branch_target, 32'd4);
    chk("dec_issue", 32'(issue_out), 32'd1);

    step(32'h20000000, 32'd9, 1, 1, 0, 0);
    chk("dbl_rd", 32'(rd_out), 32'd1);
    chk("dbl_imm", imm_out, 32'd1);
    step(32'h23C00000, 32'd10, 1, 0, 0, 0);
    chk("dbl_wrap", 32'(rd_out), 32'd0);
    step(32'h0, 32'd11, 0, 0, 0, 1);
    chk("flush_valid", 32'(valid_out), 32'd0);

    step(LW, 32'd16, 0, 0, 0, 0);
    chk("lu_lw_haz", 32'(hazard_stall), 32'd0);
    step(ADDI, 32'd17, 0, 0, 0, 0);
`ifdef ID_HAZARD_DETECT_EN
    chk("lu_haz", 32'(hazard_stall), 32'd1);
    chk("lu_issue", 32'(issue_out), 32'd0);
`endif
    step(ND, 32'd18, 0, 0, 0, 0);
    chk("lu_haz_end", 32'(hazard_stall), 32'd0);
`ifdef ID_HAZARD_DETECT_EN
    chk("lu_held_pc", pc_next_out, 32'd17);
    chk("lu_held_issue", 32'(issue_out), 32'd1);
    step(ND, 32'd18, 0, 0, 0, 0);
`endif
    chk("lu_next_pc", pc_next_out, 32'd18);
    step(LW, 32'd20, 0, 0, 0, 0);
    step(ND, 32'd21, 0, 0, 0, 0);
    chk("lu_nodep", 32'(hazard_stall), 32'd0);

    step(LW, 32'd30, 0, 0, 0, 0);
    step(ADDI, 32'd31, 0, 0, 0, 0);
    step(ADDI, 32'd32, 0, 0, 1, 1);
    chk("fl_valid", 32'(valid_out), 32'd0);
    chk("fl_haz", 32'(hazard_stall), 32'd0);
    step(ADDI, 32'd33, 0, 0, 0, 0);
    chk("fl_tracker", 32'(hazard_stall), 32'd0);
    chk("fl_pc", pc_next_out, 32'd33);

    step(32'h2C143FFD, 32'd40, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(rnd_inst(), 32'd41 + 32'(k), 0, 0, 1, 0);
      chk("st_pc", pc_next_out, 32'd40);
      chk("st_op", 32'(opcode_out), 32'd11);
    end
    step(ND, 32'd44, 0, 0, 0, 0);
    chk("st_resume", pc_next_out, 32'd44);

    do_reset();

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      step(rnd_inst(), $urandom(), 1'($urandom()), 1'($urandom()),
           $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
